decode_operand_resolver: RTL and testbench
==========================================

Name: decode_operand_resolver

Overview:
Parametrised successor to the decode-stage register-file output mux. It resolves N source operands per instruction in decode using forwarding from the memory and writeback stages. It also owns the architectural HI/LO register pair and tracks a multi-cycle multiply/divide unit (MDU). It raises a decode stall for load-use hazards and for HI/LO reads while the MDU is busy.

Parameters:
DATA_WIDTH, 32, operand/result width
REG_ADDR_WIDTH, 5, register index width; index 0 is hard-wired zero
NUM_READ_PORTS, 2, number of source operand channels
MDU_LATENCY, 4, cycles from mdu_start to HI/LO update (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
read_en  input  NUM_READ_PORTS  channel i carries a real source operand
read_addr  input  NUM_READ_PORTS*REG_ADDR_WIDTH  source index per channel (packed, channel 0 in LSBs)
read_data_reg  input  NUM_READ_PORTS*DATA_WIDTH  raw register-file read data per channel
using_HI_LO  input  NUM_READ_PORTS  channel reads HI/LO instead of the GPR
hi_lo_sel  input  NUM_READ_PORTS  1 = HI, 0 = LO (valid when using_HI_LO)
ex_mem_read  input  1  instruction in execute is a load
ex_dest  input  REG_ADDR_WIDTH  execute-stage destination
mem_reg_write  input  1  memory-stage writes a GPR
mem_dest  input  REG_ADDR_WIDTH  memory-stage destination
ALU_output_memory  input  DATA_WIDTH  memory-stage ALU result
wb_reg_write  input  1  writeback writes a GPR
wb_dest  input  REG_ADDR_WIDTH  writeback destination
wb_result  input  DATA_WIDTH  writeback result
hi_write_en  input  1  MTHI commit
lo_write_en  input  1  MTLO commit
hi_lo_write_data  input  DATA_WIDTH  MTHI/MTLO data
mdu_start  input  1  one-cycle pulse starting a mult/div
mdu_hi_result  input  DATA_WIDTH  MDU HI result, valid on completion cycle
mdu_lo_result  input  DATA_WIDTH  MDU LO result, valid on completion cycle
comparator  output  NUM_READ_PORTS*DATA_WIDTH  forwarded GPR value per channel (branch compare)
resolved_operand  output  NUM_READ_PORTS*DATA_WIDTH  final operand per channel
mdu_busy  output  1  MDU in flight
stall_decode  output  1  hold fetch/decode, bubble execute

Behaviour:
- GPR forwarding per channel i, combinational, in priority order:
  - Index 0 → 0. Never forwarded.
  - mem_reg_write && mem_dest==addr → ALU_output_memory.
  - wb_reg_write && wb_dest==addr → wb_result.
  - Otherwise read_data_reg[i].
- comparator[i] always carries the forwarded GPR value.
- resolved_operand[i]:
  - When using_HI_LO[i]: HI if hi_lo_sel[i]=1, else LO.
  - Otherwise: comparator[i].
  - Every channel uses its own read data.
- HI/LO read bypass: when hi_write_en (lo_write_en) is high in the same cycle, the read returns hi_lo_write_data instead of the stored value.
- HI/LO registers:
  - Reset to 0.
  - Updated on the clock edge from hi_write_en / lo_write_en.
- MDU counter (4 bits):
  - Reset to 0.
  - mdu_start with counter==0 loads MDU_LATENCY.
  - Nonzero counter decrements by 1 per cycle.
  - mdu_busy = (counter != 0).
- MDU completion:
  - On the cycle the counter==1, HI←mdu_hi_result and LO←mdu_lo_result at the edge.
  - If MTHI/MTLO is also asserted that cycle, the completion write wins for both registers.
- mdu_start while busy is ignored; no restart, counter unchanged.
- MTHI/MTLO while busy writes immediately. The later completion overwrites it.
- stall_decode is combinational and is 1 if any of these hold:
  - Load-use: any channel with read_en && !using_HI_LO && ex_mem_read && ex_dest!=0 && ex_dest==read_addr[i].
  - HI/LO while busy: any channel with using_HI_LO && mdu_busy. This includes the completion cycle; the first read is served the cycle after.
- Reset mid-operation:
  - Counter clears and mdu_busy drops in the cycle after reset is sampled.
  - HI/LO clear to 0.
  - No completion write occurs.
- Bubble insertion: the pipeline must not assert mdu_start or the GPR enables for bubbled instructions. No internal gating is applied.

Test Plan:
- Channel 0 addr 5, mem_reg_write dest 5 value 0xAAAA0000, wb_reg_write dest 5 value 0x1111 → comparator[0]=0xAAAA0000. Same with mem_reg_write=0 → 0x1111.
- read_addr 0, mem_dest 0, mem_reg_write=1, ALU_output_memory=0xFFFFFFFF → resolved_operand=0. Also: ex_mem_read with ex_dest=0 → stall_decode=0.
- ex_mem_read=1, ex_dest=7, channel 1 read_addr 7 read_en=1 → stall_decode=1. Same case with read_en=0 → 0.
- MDU_LATENCY=4: mdu_start at cycle 0 with results HI=0x12 LO=0x34 → mdu_busy high cycles 1-4, stall for a HI read in cycles 1-4. Cycle 5 read returns HI=0x12 with stall=0. A second mdu_start at cycle 2 has no effect.
- lo_write_en with data 0x55 → channel using LO reads 0x55 the same cycle. MTLO on the completion cycle → LO holds the MDU value afterwards.
- Reset asserted at cycle 2 of an MDU op → next cycle mdu_busy=0, HI=LO=0, and no later completion write.

Source files
------------

// File: rtl/decode_operand_resolver.sv
// Decode-stage operand resolver: per-channel GPR forwarding from MEM/WB, the
// architectural HI/LO pair, multi-cycle MDU tracking and the decode stall.
module decode_operand_resolver #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_READ_PORTS = 2,
    parameter int MDU_LATENCY    = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_READ_PORTS-1:0]              read_en,
    input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] read_addr,
    input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   read_data_reg,
    input  logic [NUM_READ_PORTS-1:0]              using_HI_LO,
    input  logic [NUM_READ_PORTS-1:0]              hi_lo_sel,
    input  logic                                   ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0]              ex_dest,
    input  logic                                   mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0]              mem_dest,
    input  logic [DATA_WIDTH-1:0]                  ALU_output_memory,
    input  logic                                   wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0]              wb_dest,
    input  logic [DATA_WIDTH-1:0]                  wb_result,
    input  logic                                   hi_write_en,
    input  logic                                   lo_write_en,
    input  logic [DATA_WIDTH-1:0]                  hi_lo_write_data,
    input  logic                                   mdu_start,
    input  logic [DATA_WIDTH-1:0]                  mdu_hi_result,
    input  logic [DATA_WIDTH-1:0]                  mdu_lo_result,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   comparator,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   resolved_operand,
    output logic                                   mdu_busy,
    output logic                                   stall_decode
);

    localparam logic [3:0] MDU_LOAD = 4'(MDU_LATENCY);

    logic [3:0]            mdu_count;
    logic [DATA_WIDTH-1:0] hi_reg;
    logic [DATA_WIDTH-1:0] lo_reg;
    logic                  mdu_done;
    logic [DATA_WIDTH-1:0] hi_view;
    logic [DATA_WIDTH-1:0] lo_view;
    logic [NUM_READ_PORTS-1:0] load_use;
    logic [NUM_READ_PORTS-1:0] hilo_wait;

    assign mdu_done = (mdu_count == 4'd1);
    assign mdu_busy = (mdu_count != 4'd0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_count <= 4'd0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            // A start while the unit is busy is dropped; no restart.
            if (mdu_count != 4'd0)
                mdu_count <= mdu_count - 4'd1;
            else if (mdu_start)
                mdu_count <= MDU_LOAD;

            // Completion overrides any MTHI/MTLO landing in the same cycle.
            if (mdu_done) begin
                hi_reg <= mdu_hi_result;
                lo_reg <= mdu_lo_result;
            end else begin
                if (hi_write_en) hi_reg <= hi_lo_write_data;
                if (lo_write_en) lo_reg <= hi_lo_write_data;
            end
        end
    end

    // Same-cycle MTHI/MTLO data is visible to readers before the edge.
    assign hi_view = hi_write_en ? hi_lo_write_data : hi_reg;
    assign lo_view = lo_write_en ? hi_lo_write_data : lo_reg;

    for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_chan
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     fwd;

        assign addr = read_addr[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

        // NOTE: the if/else chain ends in a final else, so fwd is assigned on
        // every path and no latch is inferred.
        always_comb begin
            if (addr == '0)
                fwd = '0;
            else if (mem_reg_write && (mem_dest == addr))
                fwd = ALU_output_memory;
            else if (wb_reg_write && (wb_dest == addr))
                fwd = wb_result;
            else
                fwd = read_data_reg[g*DATA_WIDTH +: DATA_WIDTH];
        end

        assign comparator[g*DATA_WIDTH +: DATA_WIDTH]       = fwd;
        assign resolved_operand[g*DATA_WIDTH +: DATA_WIDTH] =
            using_HI_LO[g] ? (hi_lo_sel[g] ? hi_view : lo_view) : fwd;

        assign load_use[g]  = read_en[g] && !using_HI_LO[g] && ex_mem_read &&
                              (ex_dest != '0) && (ex_dest == addr);
        assign hilo_wait[g] = using_HI_LO[g] && mdu_busy;
    end

    assign stall_decode = (|load_use) || (|hilo_wait);

endmodule

// File: tb/tb_decode_operand_resolver.sv
// Scoreboard bench for decode_operand_resolver: a driver pushes expected
// responses from a cycle-level reference model, a monitor pops and compares.
module tb_decode_operand_resolver;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NP  = 2;
    localparam int LAT = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NP-1:0]       read_en;
    logic [NP*AW-1:0]    read_addr;
    logic [NP*DW-1:0]    read_data_reg;
    logic [NP-1:0]       using_HI_LO;
    logic [NP-1:0]       hi_lo_sel;
    logic                ex_mem_read;
    logic [AW-1:0]       ex_dest;
    logic                mem_reg_write;
    logic [AW-1:0]       mem_dest;
    logic [DW-1:0]       ALU_output_memory;
    logic                wb_reg_write;
    logic [AW-1:0]       wb_dest;
    logic [DW-1:0]       wb_result;
    logic                hi_write_en;
    logic                lo_write_en;
    logic [DW-1:0]       hi_lo_write_data;
    logic                mdu_start;
    logic [DW-1:0]       mdu_hi_result;
    logic [DW-1:0]       mdu_lo_result;
    logic [NP*DW-1:0]    comparator;
    logic [NP*DW-1:0]    resolved_operand;
    logic                mdu_busy;
    logic                stall_decode;

    decode_operand_resolver #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NP), .MDU_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .read_en(read_en), .read_addr(read_addr),
        .read_data_reg(read_data_reg), .using_HI_LO(using_HI_LO), .hi_lo_sel(hi_lo_sel),
        .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .mem_reg_write(mem_reg_write),
        .mem_dest(mem_dest), .ALU_output_memory(ALU_output_memory),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_result(wb_result),
        .hi_write_en(hi_write_en), .lo_write_en(lo_write_en),
        .hi_lo_write_data(hi_lo_write_data), .mdu_start(mdu_start),
        .mdu_hi_result(mdu_hi_result), .mdu_lo_result(mdu_lo_result),
        .comparator(comparator), .resolved_operand(resolved_operand),
        .mdu_busy(mdu_busy), .stall_decode(stall_decode)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [NP*DW-1:0] cmp;
        logic [NP*DW-1:0] res;
        logic          busy;
        logic          stall;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: architectural HI/LO and the cycle window of the
    // MDU operation in flight (busy strictly after start, through completion).
    logic [DW-1:0] hi_m, lo_m;
    int            cyc;
    int            start_cyc;
    int            done_cyc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0; read_en = '0; read_addr = '0; read_data_reg = '0;
        using_HI_LO = '0; hi_lo_sel = '0; ex_mem_read = 1'b0; ex_dest = '0;
        mem_reg_write = 1'b0; mem_dest = '0; ALU_output_memory = '0;
        wb_reg_write = 1'b0; wb_dest = '0; wb_result = '0;
        hi_write_en = 1'b0; lo_write_en = 1'b0; hi_lo_write_data = '0;
        mdu_start = 1'b0; mdu_hi_result = '0; mdu_lo_result = '0;
    endtask

    // Compute the expected response for the inputs currently applied, queue it,
    // then advance the model across the coming clock edge.
    task automatic issue(input string name);
        exp_t          e;
        logic          busy, lu, hw;
        logic [AW-1:0] a;
        logic [DW-1:0] f, hv, lv;
        busy = (cyc > start_cyc) && (cyc <= done_cyc);
        hv   = hi_write_en ? hi_lo_write_data : hi_m;
        lv   = lo_write_en ? hi_lo_write_data : lo_m;
        lu   = 1'b0;
        hw   = 1'b0;
        for (int ch = 0; ch < NP; ch++) begin
            a = read_addr[ch*AW +: AW];
            if (a == 0)                                f = '0;
            else if (mem_reg_write && mem_dest == a)   f = ALU_output_memory;
            else if (wb_reg_write && wb_dest == a)     f = wb_result;
            else                                       f = read_data_reg[ch*DW +: DW];
            e.cmp[ch*DW +: DW] = f;
            e.res[ch*DW +: DW] = using_HI_LO[ch] ? (hi_lo_sel[ch] ? hv : lv) : f;
            if (read_en[ch] && !using_HI_LO[ch] && ex_mem_read && ex_dest != 0 && ex_dest == a)
                lu = 1'b1;
            if (using_HI_LO[ch] && busy)
                hw = 1'b1;
        end
        e.name  = name;
        e.busy  = busy;
        e.stall = lu || hw;
        sb.push_back(e);

        if (reset) begin
            hi_m = '0; lo_m = '0; start_cyc = -100; done_cyc = -100;
        end else begin
            if (cyc == done_cyc) begin
                hi_m = mdu_hi_result;
                lo_m = mdu_lo_result;
            end else begin
                if (hi_write_en) hi_m = hi_lo_write_data;
                if (lo_write_en) lo_m = hi_lo_write_data;
            end
            if (mdu_start && !busy) begin
                start_cyc = cyc;
                done_cyc  = cyc + LAT;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so one response is due every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.name, "_comparator"}, 128'(comparator), 128'(e.cmp));
                check({e.name, "_resolved"},   128'(resolved_operand), 128'(e.res));
                check({e.name, "_busy"},       128'(mdu_busy), 128'(e.busy));
                check({e.name, "_stall"},      128'(stall_decode), 128'(e.stall));
            end
        end
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        hi_m = '0; lo_m = '0; cyc = 0; start_cyc = -100; done_cyc = -100;

        // Reset state: HI read returns 0, nothing busy.
        using_HI_LO = 2'b01; hi_lo_sel = 2'b01;
        issue("reset_state");
        clear_inputs();

        // Forwarding priority on channel 0.
        read_addr[0 +: AW] = 5'd5; read_data_reg[0 +: DW] = 32'hDEAD_BEEF;
        mem_reg_write = 1'b1; mem_dest = 5'd5; ALU_output_memory = 32'hAAAA_0000;
        wb_reg_write = 1'b1; wb_dest = 5'd5; wb_result = 32'h0000_1111;
        issue("fwd_mem_first");
        mem_reg_write = 1'b0;
        issue("fwd_wb");
        wb_reg_write = 1'b0;
        issue("fwd_regfile");
        clear_inputs();

        // Index 0 is never forwarded and never causes a load-use stall.
        read_en = 2'b11; mem_reg_write = 1'b1; mem_dest = 5'd0;
        ALU_output_memory = 32'hFFFF_FFFF; read_data_reg = {32'h1234_5678, 32'h9ABC_DEF0};
        ex_mem_read = 1'b1; ex_dest = 5'd0;
        issue("zero_index");
        clear_inputs();

        // Load-use on channel 1, then the same with read_en dropped.
        ex_mem_read = 1'b1; ex_dest = 5'd7; read_addr[AW +: AW] = 5'd7; read_en = 2'b10;
        issue("load_use");
        read_en = 2'b00;
        issue("load_use_no_en");
        clear_inputs();

        // MDU op with a HI reader; a second start at cycle 2 is ignored.
        mdu_start = 1'b1;
        issue("mdu_c0");
        mdu_start = 1'b0; using_HI_LO = 2'b01; hi_lo_sel = 2'b01;
        issue("mdu_c1");
        mdu_start = 1'b1;
        issue("mdu_c2");
        mdu_start = 1'b0;
        issue("mdu_c3");
        mdu_hi_result = 32'h12; mdu_lo_result = 32'h34;
        issue("mdu_c4");
        mdu_hi_result = 32'hEE; mdu_lo_result = 32'hFF;
        issue("mdu_c5");
        hi_lo_sel = 2'b00;
        issue("mdu_c6_lo");
        clear_inputs();

        // MTLO bypass, then MTLO colliding with completion.
        lo_write_en = 1'b1; hi_lo_write_data = 32'h55; using_HI_LO = 2'b10; hi_lo_sel = 2'b00;
        issue("mtlo_bypass");
        lo_write_en = 1'b0;
        issue("mtlo_held");
        mdu_start = 1'b1;
        issue("mdu2_c0");
        mdu_start = 1'b0;
        for (int i = 1; i < LAT; i++) issue("mdu2_wait");
        lo_write_en = 1'b1; hi_lo_write_data = 32'h99;
        mdu_hi_result = 32'h66; mdu_lo_result = 32'h77;
        issue("mdu2_done_mtlo");
        clear_inputs();
        using_HI_LO = 2'b11; hi_lo_sel = 2'b01;
        issue("mdu2_after");
        clear_inputs();

        // Reset in the middle of an MDU operation.
        mdu_start = 1'b1;
        issue("rst_c0");
        mdu_start = 1'b0;
        issue("rst_c1");
        reset = 1'b1;
        issue("rst_c2");
        reset = 1'b0; using_HI_LO = 2'b11; hi_lo_sel = 2'b01;
        mdu_hi_result = 32'hBAD0; mdu_lo_result = 32'hBAD1;
        for (int i = 0; i < LAT + 1; i++) issue("rst_after");
        clear_inputs();

        // Randomised traffic with narrow address ranges to provoke hits.
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            read_en = NP'($urandom);
            using_HI_LO = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
            hi_lo_sel = NP'($urandom);
            for (int ch = 0; ch < NP; ch++) begin
                read_addr[ch*AW +: AW]   = AW'($urandom_range(0, 7));
                read_data_reg[ch*DW +: DW] = $urandom;
            end
            ex_mem_read = ($urandom_range(0, 3) == 0);
            ex_dest = AW'($urandom_range(0, 7));
            mem_reg_write = $urandom_range(0, 1) == 1;
            mem_dest = AW'($urandom_range(0, 7));
            ALU_output_memory = $urandom;
            wb_reg_write = $urandom_range(0, 1) == 1;
            wb_dest = AW'($urandom_range(0, 7));
            wb_result = $urandom;
            hi_write_en = ($urandom_range(0, 4) == 0);
            lo_write_en = ($urandom_range(0, 4) == 0);
            hi_lo_write_data = $urandom;
            mdu_start = ($urandom_range(0, 5) == 0);
            mdu_hi_result = $urandom;
            mdu_lo_result = $urandom;
            issue("random");
        end
        clear_inputs();

        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d responses unchecked, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
